// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: IF stall/flush, PC and IF/ID write enables, ID/EX bubble.
// Define HAZARD_CNT_EN to add saturating stall/flush event counters (stall_cnt_o, flush_cnt_o).
module hazard_ctrl_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_use_rs_i,
   input  logic              id_use_rt_i,
   input  logic              id_branch_i,
   input  logic              id_taken_i,
   input  logic              id_jump_i,
   input  logic              ex_regwrite_i,
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              mem_memread_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   output logic              pc_write_o,
   output logic              if_id_write_o,
   output logic              if_stall_o,
   output logic              if_flush_o,
   output logic              id_ex_bubble_o
`ifdef HAZARD_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

   // state | meaning
   // IDLE  | CPU not running, all outputs low
   // RUN   | normal operation, hazards evaluated every cycle
   // HOLD  | extra stall cycles of a multi-cycle hazard, inputs ignored
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [1:0]  hold_cnt_q, hold_cnt_d;
   logic        hit_ex, hit_mem;
   logic [1:0]  need_n;

   // Register 0 is hardwired, so it can never carry a dependency.
   assign hit_ex  = (ex_rd_i != '0) &
                    ((id_use_rs_i & (id_rs_i == ex_rd_i)) | (id_use_rt_i & (id_rt_i == ex_rd_i)));
   assign hit_mem = (mem_rd_i != '0) &
                    ((id_use_rs_i & (id_rs_i == mem_rd_i)) | (id_use_rt_i & (id_rt_i == mem_rd_i)));

   always_comb begin
      need_n = 2'd0;
      if (id_branch_i & hit_ex & ex_memread_i)         need_n = 2'd2;
      else if (id_branch_i & hit_ex & ex_regwrite_i)   need_n = 2'd1;
      else if (id_branch_i & hit_mem & mem_memread_i)  need_n = 2'd1;
      else if (!id_branch_i & hit_ex & ex_memread_i)   need_n = 2'd1;
   end

   always_comb begin
      state_d        = state_q;
      hold_cnt_d     = hold_cnt_q;
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_stall_o     = 1'b0;
      if_flush_o     = 1'b0;
      id_ex_bubble_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
         end
         RUN: begin
            if (need_n != 2'd0) begin
               if_stall_o     = 1'b1;
               id_ex_bubble_o = 1'b1;
               if (need_n == 2'd2) begin
                  state_d    = HOLD;
                  hold_cnt_d = 2'd1;
               end
            end else begin
               pc_write_o    = 1'b1;
               if_id_write_o = 1'b1;
               if_flush_o    = (id_branch_i & id_taken_i) | id_jump_i;
            end
         end
         HOLD: begin
            if_stall_o     = 1'b1;
            id_ex_bubble_o = 1'b1;
            hold_cnt_d     = hold_cnt_q - 2'd1;
            if (hold_cnt_q <= 2'd1) state_d = RUN;
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = 2'd0;
         end
      endcase
      // Dropping the run enable wins over everything, including a pending hold.
      if (!start_i) begin
         state_d    = IDLE;
         hold_cnt_d = 2'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         hold_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

`ifdef HAZARD_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (if_stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (if_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
